// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_ADDR_W_DEF = 14;
    localparam int c_DATA_W_DEF = 32;

    // Peripheral windows, decoded from address bits [13:10]
    localparam logic [3:0] c_REGION_PERIPH_A = 4'b1000;
    localparam logic [3:0] c_REGION_PERIPH_B = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    function automatic logic is_periph(input logic [3:0] region);
        return (region == c_REGION_PERIPH_A) || (region == c_REGION_PERIPH_B);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arb
// Description : Two-way round-robin picker; bit 0 = instruction, bit 1 = data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arb (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // last_i = 1 means the data port won most recently, so instruction wins a tie
    always_comb begin
        gnt_o[0] = req0_i & (~req1_i |  last_i);
        gnt_o[1] = req1_i & (~req0_i | ~last_i);
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates an instruction and a data port onto one memory bus,
//               stretching peripheral-window accesses by PERIPH_WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W_DEF,
    parameter int DATA_W      = c_DATA_W_DEF,
    parameter int PERIPH_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              bus_ren,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [2:0] c_WAIT_LOAD = 3'(PERIPH_WAIT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        w_rr_gnt;
    logic [1:0]        w_gnt;
    logic              w_grant;
    logic              w_sel_d;
    logic              w_win_we;
    logic              w_win_periph;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    mem_rr_arb u_rr (
        .req0_i (i_req),
        .req1_i (d_req),
        .last_i (last_q),
        .gnt_o  (w_rr_gnt)
    );

    // Grants are suppressed while reset is held so every output reads zero
    always_comb begin
        w_gnt        = (rst_n && state_q != ST_WAIT) ? w_rr_gnt : 2'b00;
        w_grant      = |w_gnt;
        w_sel_d      = w_gnt[1];
        w_win_we     = w_sel_d & d_we;
        w_win_addr   = w_sel_d ? d_addr : i_addr;
        w_win_wdata  = w_sel_d ? d_wdata : wdata_q;
        w_win_periph = is_periph(w_win_addr[13:10]);
    end

    always_comb begin
        i_gnt     = w_gnt[0];
        d_gnt     = w_gnt[1];
        bus_ren   = (w_grant & ~w_win_we) | (state_q == ST_WAIT && !we_q);
        bus_wen   = w_grant & w_win_we;
        bus_addr  = w_grant ? w_win_addr : addr_q;
        bus_wdata = w_grant ? w_win_wdata : wdata_q;
        i_rvalid  = (state_q == ST_RESP) && !owner_q;
        d_rvalid  = (state_q == ST_RESP) &&  owner_q;
        i_rdata   = i_rvalid ? bus_rdata : '0;
        d_rdata   = d_rvalid ? bus_rdata : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (w_grant) begin
            owner_d = w_sel_d;
            we_d    = w_win_we;
            last_d  = w_sel_d;
            addr_d  = w_win_addr;
            wdata_d = w_win_wdata;
            if (w_win_periph) begin
                state_d = ST_WAIT;
                cnt_d   = c_WAIT_LOAD;
            end else if (w_win_we) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_RESP;
            end
        end else begin
            case (state_q)
                ST_RESP: state_d = ST_IDLE;
                ST_WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = we_q ? ST_IDLE : ST_RESP;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scoreboard bench for mem_arbiter (PERIPH_WAIT = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [13:0] i_addr, d_addr;
    logic [31:0] d_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, bus_ren, bus_wen;
    logic [31:0] i_rdata, d_rdata, bus_wdata;
    logic [13:0] bus_addr;

    typedef struct {
        int          cyc;
        logic        port;
        logic [13:0] addr;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t q_gnt[$];
    exp_t q_bus[$];
    exp_t q_rv[$];
    exp_t m_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter #(.ADDR_W(14), .DATA_W(32), .PERIPH_WAIT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data tags the address read on the previous cycle
    always @(posedge clk) bus_rdata <= bus_ren ? (32'hC0DE_0000 | {18'd0, bus_addr}) : 32'h0BAD_0BAD;

    function automatic logic [31:0] rd(input logic [13:0] a);
        return 32'hC0DE_0000 | {18'd0, a};
    endfunction

    function automatic logic [63:0] pk(input int c, input logic p, input logic [13:0] a,
                                       input logic w, input logic [31:0] d);
        return {c[15:0], p, w, a, d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d, nothing expected", nm, cyc);
    endtask

    task automatic exp_gnt(input int c, input logic p, input logic [13:0] a);
        q_gnt.push_back('{c, p, a, 1'b0, 32'd0});
    endtask

    task automatic exp_bus(input int c, input logic we, input logic [13:0] a, input logic [31:0] d);
        q_bus.push_back('{c, 1'b0, a, we, d});
    endtask

    task automatic exp_rv(input int c, input logic p, input logic [31:0] d);
        q_rv.push_back('{c, p, 14'd0, 1'b0, d});
    endtask

    // Monitor: every grant, strobe and rvalid must match the head of its queue
    always @(negedge clk) begin
        if (i_gnt || d_gnt) begin
            if (q_gnt.size() == 0) unexpected("grant");
            else begin
                m_e = q_gnt.pop_front();
                chk("grant", pk(cyc, d_gnt, bus_addr, i_gnt & d_gnt, 32'd0),
                             pk(m_e.cyc, m_e.port, m_e.addr, 1'b0, 32'd0));
            end
        end
        if (bus_ren || bus_wen) begin
            if (q_bus.size() == 0) unexpected("bus_strobe");
            else begin
                m_e = q_bus.pop_front();
                chk("bus_strobe", pk(cyc, bus_ren, bus_addr, bus_wen, bus_wen ? bus_wdata : 32'd0),
                                  pk(m_e.cyc, ~m_e.we, m_e.addr, m_e.we, m_e.we ? m_e.data : 32'd0));
            end
        end
        if (i_rvalid || d_rvalid) begin
            if (q_rv.size() == 0) unexpected("rvalid");
            else begin
                m_e = q_rv.pop_front();
                chk("rvalid", pk(cyc, d_rvalid, 14'd0, i_rvalid & d_rvalid, d_rvalid ? d_rdata : i_rdata),
                              pk(m_e.cyc, m_e.port, 14'd0, 1'b0, m_e.data));
                chk("rdata_nonowner", 64'(d_rvalid ? i_rdata : d_rdata), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctl"}, 64'({i_gnt, d_gnt, i_rvalid, d_rvalid, bus_ren, bus_wen, bus_addr}), 64'd0);
        chk({nm, "_wdata"}, 64'(bus_wdata), 64'd0);
        chk({nm, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    endtask

    int c;

    initial begin
        // Reset with both requests up: nothing may leak out
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 14'h010; d_addr = 14'h123; d_wdata = 32'h5555_AAAA;
        tick(); tick();
        check_zero("reset");
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Single RAM read, granted in the first cycle after release
        tick(); c = cyc;
        exp_gnt(c, 1'b0, 14'h010); exp_bus(c, 1'b0, 14'h010, 0); exp_rv(c + 1, 1'b0, rd(14'h010));
        i_req = 1'b1; i_addr = 14'h010;
        tick(); i_req = 1'b0;
        tick();

        // Contention straight out of reset: D, I, D, I
        rst_n = 1'b0; tick(); @(negedge clk); rst_n = 1'b1;
        tick(); c = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_gnt(c + k, (k % 2 == 0), (k % 2 == 0) ? 14'h030 : 14'h020);
            exp_bus(c + k, 1'b0, (k % 2 == 0) ? 14'h030 : 14'h020, 0);
            exp_rv(c + k + 1, (k % 2 == 0), rd((k % 2 == 0) ? 14'h030 : 14'h020));
        end
        i_req = 1'b1; i_addr = 14'h020; d_req = 1'b1; d_we = 1'b0; d_addr = 14'h030;
        repeat (4) tick();
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Peripheral read with an instruction request waiting through WAIT
        tick(); c = cyc;
        exp_gnt(c, 1'b1, 14'h2004);
        exp_bus(c, 1'b0, 14'h2004, 0); exp_bus(c + 1, 1'b0, 14'h2004, 0); exp_bus(c + 2, 1'b0, 14'h2004, 0);
        exp_gnt(c + 3, 1'b0, 14'h044); exp_bus(c + 3, 1'b0, 14'h044, 0);
        exp_rv(c + 3, 1'b1, rd(14'h2004)); exp_rv(c + 4, 1'b0, rd(14'h044));
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h2004;
        tick(); d_req = 1'b0; i_req = 1'b1; i_addr = 14'h044;
        tick(); tick(); tick();
        i_req = 1'b0;
        tick();

        // Peripheral write; a dropped data request during WAIT has no effect
        tick(); c = cyc;
        exp_gnt(c, 1'b1, 14'h3000); exp_bus(c, 1'b1, 14'h3000, 32'hDEAD_BEEF);
        exp_gnt(c + 3, 1'b0, 14'h050); exp_bus(c + 3, 1'b0, 14'h050, 0); exp_rv(c + 4, 1'b0, rd(14'h050));
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h3000; d_wdata = 32'hDEAD_BEEF;
        tick(); d_addr = 14'h0777; i_req = 1'b1; i_addr = 14'h050;
        chk("wait_addr_hold", 64'(bus_addr), 64'h3000);
        tick(); d_req = 1'b0;
        tick(); tick();
        i_req = 1'b0;
        tick();

        // RAM write followed at once by an instruction read
        tick(); c = cyc;
        exp_gnt(c, 1'b1, 14'h0100); exp_bus(c, 1'b1, 14'h0100, 32'h1234_5678);
        exp_gnt(c + 1, 1'b0, 14'h060); exp_bus(c + 1, 1'b0, 14'h060, 0); exp_rv(c + 2, 1'b0, rd(14'h060));
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0100; d_wdata = 32'h1234_5678;
        tick(); d_req = 1'b0; i_req = 1'b1; i_addr = 14'h060;
        tick(); i_req = 1'b0;
        tick(); tick();
        chk("idle_hold", 64'({bus_ren, bus_wen, bus_addr}), 64'h060);

        // Pointer after a data grant: tie goes to instruction, then data
        tick(); c = cyc;
        exp_gnt(c, 1'b1, 14'h070); exp_bus(c, 1'b0, 14'h070, 0); exp_rv(c + 1, 1'b1, rd(14'h070));
        exp_gnt(c + 1, 1'b0, 14'h080); exp_bus(c + 1, 1'b0, 14'h080, 0); exp_rv(c + 2, 1'b0, rd(14'h080));
        exp_gnt(c + 2, 1'b1, 14'h090); exp_bus(c + 2, 1'b0, 14'h090, 0); exp_rv(c + 3, 1'b1, rd(14'h090));
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h070;
        tick(); d_addr = 14'h090; i_req = 1'b1; i_addr = 14'h080;
        tick(); i_req = 1'b0;
        tick(); d_req = 1'b0;
        tick();

        // Reset one cycle into a peripheral read's WAIT
        tick(); c = cyc;
        exp_gnt(c, 1'b1, 14'h2008); exp_bus(c, 1'b0, 14'h2008, 0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h2008;
        tick(); d_req = 1'b0; rst_n = 1'b0;
        #1 check_zero("reset_midwait");
        tick(); tick();
        @(negedge clk); rst_n = 1'b1;
        repeat (6) tick();

        chk("pending_grants", 64'(q_gnt.size()), 64'd0);
        chk("pending_strobes", 64'(q_bus.size()), 64'd0);
        chk("pending_rvalids", 64'(q_rv.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 14, bus word address width; DATA_W, default 32, data width; PERIPH_WAIT, default 2, extra busy cycles per peripheral access (legal range 1..7).
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have the instruction port: i_req input 1, read request; i_addr input ADDR_W, address; i_gnt output 1, request accepted; i_rvalid output 1, read data valid; i_rdata output DATA_W, read data.
REQ-004 SHALL have the data port: d_req input 1, request; d_we input 1, 1 = write; d_addr input ADDR_W, address; d_wdata input DATA_W, write data; d_gnt output 1, request accepted; d_rvalid output 1, read data valid; d_rdata output DATA_W, read data.
REQ-005 SHALL have the shared bus port: bus_ren output 1, read enable; bus_wen output 1, write enable; bus_addr output ADDR_W, address; bus_wdata output DATA_W, write data; bus_rdata input DATA_W, data, valid one cycle after bus_ren.

Function
REQ-006 SHALL classify an address as peripheral when addr[13:10] is 4'b1000 or 4'b1100, and as RAM otherwise.
REQ-007 SHALL implement states IDLE, RESP, WAIT.
REQ-008 SHALL issue a grant only in IDLE or RESP, and only when at least one req is high.
REQ-009 Grant cycle: SHALL combinationally assert the winner's gnt, drive bus_addr/bus_wdata from the winner, and assert bus_ren (read) or bus_wen (write) for exactly that cycle.
REQ-010 Arbitration: SHALL grant a sole requester; on simultaneous requests, SHALL grant the port not granted most recently; the last-granted pointer updates on every grant.
REQ-011 Transitions after a grant: RAM read -> RESP; RAM write -> IDLE; peripheral access, read or write -> WAIT, with the wait counter loaded with PERIPH_WAIT.
REQ-012 With no grant: RESP -> IDLE.
REQ-013 In WAIT: SHALL decrement the counter each cycle, hold bus_addr at the latched address, and re-assert bus_ren every WAIT cycle for reads (bus_wen stays low).
REQ-014 SHALL leave WAIT when the counter reaches 0: read -> RESP; write -> IDLE.
REQ-015 In WAIT: SHALL deassert both gnt outputs.
REQ-016 In RESP: SHALL assert rvalid for exactly one cycle to the latched owner, and drive that port's rdata = bus_rdata.
REQ-017 SHALL drive non-owner rdata to 0.
REQ-018 Timing: RAM read -> rvalid exactly 1 cycle after the grant; peripheral read -> rvalid exactly PERIPH_WAIT+1 cycles after the grant; writes SHALL never produce rvalid.
REQ-019 SHALL support back-to-back operation: a new grant in RESP SHALL coincide with the previous read's rvalid, sustaining one RAM read per cycle.
REQ-020 When idle: bus_ren = bus_wen = 0, and bus_addr/bus_wdata SHALL hold their last values.
REQ-021 A requester dropping req without a grant SHALL be legal and SHALL have no effect.
REQ-022 SHALL ignore d_we when d_req is low, and SHALL treat the instruction port as always read.

Reset
REQ-023 On rst_n low, asynchronously: state = IDLE, counter = 0, owner cleared, last-granted pointer = instruction port (data port wins the first tie), and all outputs = 0.
REQ-024 Reset during WAIT or RESP SHALL abandon the access: no rvalid after reset release, and no bus strobe until a new grant.
REQ-025 The first grant SHALL be possible in the first clk edge cycle after rst_n rises.

Structure
REQ-026 Package mem_pkg SHALL hold the state enum, the region constants 4'b1000 and 4'b1100, and the ADDR_W/DATA_W defaults.
REQ-027 The 2-way round-robin picker SHALL be sub-module mem_rr_arb (inputs: two req, last pointer; outputs: one-hot grant).
REQ-028 All state SHALL reside in a single always_ff; outputs SHALL be decoded in always_comb.

Verification
REQ-029 Single RAM read: i_req, i_addr=0x010 -> i_gnt plus bus_ren with bus_addr=0x010 same cycle; next cycle i_rvalid=1, i_rdata=bus_rdata.
REQ-030 Contention from reset: i_req and d_req both held -> grants in order D, I, D, I, with one grant per cycle for RAM reads.
REQ-031 Peripheral read: d_req, d_we=0, d_addr=0x2004, PERIPH_WAIT=2 -> bus_ren for 3 cycles at 0x2004, no gnt during WAIT, d_rvalid at grant+3.
REQ-032 Writes: d_we=1, d_addr=0x3000, d_wdata=0xDEADBEEF -> one-cycle bus_wen, 2 busy cycles, and no d_rvalid; a RAM write to 0x0100 immediately followed by an i_req is granted next cycle.
REQ-033 Reset mid-WAIT: assert rst_n=0 at grant+1 of a peripheral read -> all outputs 0 immediately, and no d_rvalid after release.
